// File: rtl/freq_counter_multi.sv
// freq_counter_multi: multi-channel direct-count frequency meter over a shared gate window.
// Latency: sig_in rise -> edge counted SYNC_STAGES+1 cycles later; results latched 1 cycle after window end.
// Backpressure: none; cnt_valid is a one-cycle strobe and the buffers hold until the next window end.
// Ports: sys_clk/rst_n clock and async active-low reset; sig_in[CH] async test inputs; en measurement
//   enable; gate_sel selects window length (CLK_HZ / 1, 10, 100, 1000 cycles); sig_freq_cnt_buf holds
//   one CNT_W count per channel; cnt_ovf per-channel saturation flag; cnt_valid update strobe;
//   gate_active high while a window is running.
module freq_counter_multi #(
   parameter int CH          = 4,
   parameter int CNT_W       = 32,
   parameter int CLK_HZ      = 100_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic [CH-1:0]       sig_in,
   input  logic                en,
   input  logic [1:0]          gate_sel,
   output logic [CH*CNT_W-1:0] sig_freq_cnt_buf,
   output logic [CH-1:0]       cnt_ovf,
   output logic                cnt_valid,
   output logic                gate_active
);

   // CLK_HZ is a multiple of 1000, never a power of two, so clog2 bits also hold CLK_HZ itself.
   localparam int GW = $clog2(CLK_HZ);
   localparam logic [GW-1:0]    LEN_1S   = GW'(CLK_HZ);
   localparam logic [GW-1:0]    LEN_100M = GW'(CLK_HZ / 10);
   localparam logic [GW-1:0]    LEN_10M  = GW'(CLK_HZ / 100);
   localparam logic [GW-1:0]    LEN_1M   = GW'(CLK_HZ / 1000);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [CH-1:0]       sync_q [SYNC_STAGES];
   logic [CH-1:0]       prev_q;
   logic [CH-1:0]       edge_w;
   logic [GW-1:0]       gate_cnt_q, gate_cnt_d;
   logic [GW-1:0]       gate_len_q, gate_len_d;
   logic [GW-1:0]       sel_len;
   logic                win_last;
   logic [CNT_W-1:0]    acc_q [CH];
   logic [CNT_W-1:0]    acc_d [CH];
   logic [CNT_W-1:0]    acc_inc [CH];
   logic [CH-1:0]       sat_hit;
   logic [CH-1:0]       acc_ovf_q, acc_ovf_d;
   logic [CH*CNT_W-1:0] buf_q, buf_d;
   logic [CH-1:0]       ovf_q, ovf_d;
   logic                valid_q, valid_d;

   // Synchroniser chain plus previous-value flop; not gated by en so edges stay coherent across aborts.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= sig_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_w = sync_q[SYNC_STAGES-1] & ~prev_q;

   always_comb begin
      sel_len = LEN_1S;
      unique case (gate_sel)
         2'd0: sel_len = LEN_1S;
         2'd1: sel_len = LEN_100M;
         2'd2: sel_len = LEN_10M;
         2'd3: sel_len = LEN_1M;
      endcase
   end

   // Saturating increment: an edge arriving at full scale is dropped and flagged instead of wrapping.
   always_comb begin
      sat_hit = '0;
      acc_inc = acc_q;
      for (int i = 0; i < CH; i++) begin
         sat_hit[i] = edge_w[i] & (acc_q[i] == CNT_MAX);
         if (edge_w[i] && !sat_hit[i]) acc_inc[i] = acc_q[i] + CNT_W'(1);
      end
   end

   assign win_last = (gate_cnt_q == gate_len_q - GW'(1));

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      gate_len_d = gate_len_q;
      acc_d      = acc_q;
      acc_ovf_d  = acc_ovf_q;
      buf_d      = buf_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            gate_cnt_d = '0;
            gate_len_d = sel_len;
            acc_ovf_d  = '0;
            for (int i = 0; i < CH; i++) acc_d[i] = '0;
            if (en) state_d = RUN;
         end
         RUN: begin
            if (!en) begin
               // Abort wins even on the last window cycle: nothing is latched.
               state_d = IDLE;
            end else if (win_last) begin
               // The last-cycle edge belongs to the closing window; the next window starts from zero.
               for (int i = 0; i < CH; i++) begin
                  buf_d[i*CNT_W +: CNT_W] = acc_inc[i];
                  ovf_d[i]                = acc_ovf_q[i] | sat_hit[i];
                  acc_d[i]                = '0;
               end
               acc_ovf_d  = '0;
               valid_d    = 1'b1;
               gate_cnt_d = '0;
               gate_len_d = sel_len;
            end else begin
               acc_d      = acc_inc;
               acc_ovf_d  = acc_ovf_q | sat_hit;
               gate_cnt_d = gate_cnt_q + GW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gate_cnt_q <= '0;
         gate_len_q <= LEN_1S;
         for (int i = 0; i < CH; i++) acc_q[i] <= '0;
         acc_ovf_q  <= '0;
         buf_q      <= '0;
         ovf_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         gate_len_q <= gate_len_d;
         acc_q      <= acc_d;
         acc_ovf_q  <= acc_ovf_d;
         buf_q      <= buf_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign sig_freq_cnt_buf = buf_q;
   assign cnt_ovf          = ovf_q;
   assign cnt_valid        = valid_q;
   assign gate_active      = (state_q == RUN);

endmodule

// File: tb/tb_freq_counter_multi.sv
// tb_freq_counter_multi: checks freq_counter_multi against a window-level behavioural model.
// Two instances share stimulus: a wide one (16-bit counts) and a narrow one (4-bit) that saturates.
// Inputs are driven on the falling clock edge; outputs are compared on every falling edge.
module tb_freq_counter_multi;
   localparam int CH = 4;
   localparam int WA = 16;
   localparam int WB = 4;
   localparam int HZ = 10_000;
   localparam int S  = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [1:0]       gate_sel;
   logic [CH-1:0]    sig_in;
   logic [CH*WA-1:0] buf_a;
   logic [CH*WB-1:0] buf_b;
   logic [CH-1:0]    ovf_a, ovf_b;
   logic             val_a, val_b, act_a, act_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ncnt = 0;
   int per [CH];
   int ph [CH];
   logic          manual = 1'b0;
   logic [CH-1:0] man_sig = '0;

   freq_counter_multi #(.CH(CH), .CNT_W(WA), .CLK_HZ(HZ), .SYNC_STAGES(S)) u_a (
      .sys_clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .gate_sel(gate_sel),
      .sig_freq_cnt_buf(buf_a), .cnt_ovf(ovf_a), .cnt_valid(val_a), .gate_active(act_a));

   freq_counter_multi #(.CH(CH), .CNT_W(WB), .CLK_HZ(HZ), .SYNC_STAGES(S)) u_b (
      .sys_clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .gate_sel(gate_sel),
      .sig_freq_cnt_buf(buf_b), .cnt_ovf(ovf_b), .cnt_valid(val_b), .gate_active(act_b));

   always #5 clk = ~clk;

   initial forever begin @(posedge clk); cyc++; end
   initial forever begin @(negedge clk); ncnt++; end

   // Square-wave generator: high for the first half of each period; per = 0 means constant low.
   always_comb begin
      sig_in = '0;
      for (int i = 0; i < CH; i++) begin
         if (manual) sig_in[i] = man_sig[i];
         else if (per[i] > 0) sig_in[i] = ((ncnt + ph[i]) % per[i]) < (per[i] / 2);
      end
   end

   function automatic int glen(input logic [1:0] sel);
      case (sel)
         2'd0:    return HZ;
         2'd1:    return HZ / 10;
         2'd2:    return HZ / 100;
         default: return HZ / 1000;
      endcase
   endfunction

   function automatic longint sat(input int c, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (longint'(c) > mx) ? mx : longint'(c);
   endfunction

   function automatic logic [63:0] ba(input int i);
      return 64'(buf_a[i*WA +: WA]);
   endfunction

   function automatic logic [63:0] bb(input int i);
      return 64'(buf_b[i*WB +: WB]);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Behavioural model: unbounded edge counts per window, clamped only when the result is published.
   bit            m_run = 1'b0;
   int            m_rem = 0;
   int            m_cnt [CH];
   longint        exp_buf_a [CH];
   longint        exp_buf_b [CH];
   logic [CH-1:0] exp_ovf_a = '0;
   logic [CH-1:0] exp_ovf_b = '0;
   logic          exp_val = 1'b0;
   logic [CH-1:0] hist [S+1];
   logic [CH-1:0] edges;

   initial begin
      for (int i = 0; i < CH; i++) begin m_cnt[i] = 0; exp_buf_a[i] = 0; exp_buf_b[i] = 0; end
      for (int k = 0; k <= S; k++) hist[k] = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_run = 1'b0; m_rem = 0; exp_val = 1'b0; exp_ovf_a = '0; exp_ovf_b = '0;
            for (int i = 0; i < CH; i++) begin m_cnt[i] = 0; exp_buf_a[i] = 0; exp_buf_b[i] = 0; end
            for (int k = 0; k <= S; k++) hist[k] = '0;
         end else begin
            // A rise sampled S clocks ago, not seen the clock before that, is counted now.
            edges   = hist[S-1] & ~hist[S];
            exp_val = 1'b0;
            if (!m_run) begin
               if (en) begin
                  m_run = 1'b1;
                  m_rem = glen(gate_sel);
                  for (int i = 0; i < CH; i++) m_cnt[i] = 0;
               end
            end else if (!en) begin
               m_run = 1'b0;
            end else begin
               for (int i = 0; i < CH; i++) m_cnt[i] += int'(edges[i]);
               m_rem--;
               if (m_rem == 0) begin
                  for (int i = 0; i < CH; i++) begin
                     exp_buf_a[i] = sat(m_cnt[i], WA);
                     exp_buf_b[i] = sat(m_cnt[i], WB);
                     exp_ovf_a[i] = (longint'(m_cnt[i]) > sat(m_cnt[i], WA));
                     exp_ovf_b[i] = (longint'(m_cnt[i]) > sat(m_cnt[i], WB));
                     m_cnt[i] = 0;
                  end
                  exp_val = 1'b1;
                  m_rem   = glen(gate_sel);
               end
            end
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sig_in;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("active_a", 64'(act_a), 64'(m_run));
      chk("active_b", 64'(act_b), 64'(m_run));
      chk("valid_a", 64'(val_a), 64'(exp_val));
      chk("valid_b", 64'(val_b), 64'(exp_val));
      chk("ovf_a", 64'(ovf_a), 64'(exp_ovf_a));
      chk("ovf_b", 64'(ovf_b), 64'(exp_ovf_b));
      for (int i = 0; i < CH; i++) begin
         chk($sformatf("buf_a[%0d]", i), ba(i), 64'(exp_buf_a[i]));
         chk($sformatf("buf_b[%0d]", i), bb(i), 64'(exp_buf_b[i]));
      end
   end

   task automatic wait_strobe(output int t);
      int n;
      n = 0;
      t = -1;
      do begin
         @(negedge clk);
         n++;
      end while (!val_a && n < 400);
      if (val_a) t = cyc;
      else chk("strobe_timeout", 64'd0, 64'd1);
   endtask

   int t, t0, t1, t2, t3, r, a, p, n;

   initial begin
      rst_n = 1'b0; en = 1'b0; gate_sel = 2'd2;
      per = '{10, 4, 0, 50};
      ph[0] = $urandom_range(0, 9); ph[1] = $urandom_range(0, 3);
      ph[2] = 0;                    ph[3] = $urandom_range(0, 49);
      repeat (3) @(negedge clk);
      chk("rst_buf_a", 64'(buf_a), 64'd0);
      chk("rst_ovf_a", 64'(ovf_a), 64'd0);
      chk("rst_valid", 64'(val_a), 64'd0);
      chk("rst_active", 64'(act_a), 64'd0);

      // Basic count; first strobe 1 + gate_len after reset release.
      rst_n = 1'b1; en = 1'b1; r = cyc;
      wait_strobe(t);
      chk("first_strobe_delay", 64'(t - r), 64'd101);
      wait_strobe(t0);
      chk("strobe_period", 64'(t0 - t), 64'd100);
      chk("basic_ch0", ba(0), 64'd10);
      chk("basic_ch1", ba(1), 64'd25);
      chk("basic_ch2", ba(2), 64'd0);
      chk("basic_ch3", ba(3), 64'd2);
      chk("basic_ovf", 64'(ovf_a), 64'd0);
      chk("narrow_ch1_sat", bb(1), 64'd15);
      chk("narrow_ovf", 64'(ovf_b), 64'b0010);

      // Saturation on channel 0 of the narrow instance, then recovery.
      per[0] = 4;
      wait_strobe(t); wait_strobe(t);
      chk("sat_buf0", bb(0), 64'd15);
      chk("sat_ovf0", 64'(ovf_b[0]), 64'd1);
      chk("sat_wide_buf0", ba(0), 64'd25);
      per[0] = 10;
      wait_strobe(t); wait_strobe(t);
      chk("unsat_buf0", bb(0), 64'd10);
      chk("unsat_ovf0", 64'(ovf_b[0]), 64'd0);

      // Gate change mid-window takes effect only at the next window start.
      wait_strobe(t);
      repeat (30) @(negedge clk);
      gate_sel = 2'd3;
      wait_strobe(t1);
      chk("gate_chg_cur", 64'(t1 - t), 64'd100);
      wait_strobe(t2);
      chk("gate_chg_next", 64'(t2 - t1), 64'd10);
      chk("gate_chg_buf0", ba(0), 64'd1);
      wait_strobe(t3);
      chk("gate_chg_next2", 64'(t3 - t2), 64'd10);
      gate_sel = 2'd2;
      wait_strobe(t);
      chk("gate_back_10", 64'(t - t3), 64'd10);
      wait_strobe(t0);
      chk("gate_back_100", 64'(t0 - t), 64'd100);

      // Abort 40 cycles into a window, re-enable 5 cycles later.
      repeat (40) @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_active", 64'(act_a), 64'd0);
      chk("abort_hold_ch1", ba(1), 64'd25);
      repeat (3) @(negedge clk);
      en = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!act_a && n < 10);
      chk("abort_restart", 64'(act_a), 64'd1);
      a = cyc;
      wait_strobe(t);
      chk("abort_full_window", 64'(t - a), 64'd100);

      // Boundary: an edge on the last window cycle (ch2) and on the next window's first cycle (ch0).
      manual = 1'b1; man_sig = '0;
      wait_strobe(p); wait_strobe(p);
      while (cyc < p + 97) @(negedge clk);
      man_sig[2] = 1'b1;
      @(negedge clk);
      man_sig[0] = 1'b1;
      wait_strobe(t);
      chk("bnd_strobe", 64'(t - p), 64'd100);
      chk("bnd_last_ch2", ba(2), 64'd1);
      chk("bnd_last_ch0", ba(0), 64'd0);
      wait_strobe(t);
      chk("bnd_first_ch0", ba(0), 64'd1);
      chk("bnd_first_ch2", ba(2), 64'd0);
      man_sig = '0;
      manual  = 1'b0;

      // Randomised periods, phases, gate lengths and short enable drops.
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < CH; i++) begin
            per[i] = int'($urandom_range(4, 30));
            ph[i]  = int'($urandom_range(0, 29));
         end
         gate_sel = 2'($urandom_range(2, 3));
         n = int'($urandom_range(60, 300));
         for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         end
         en = 1'b1;
      end

      // Asynchronous reset mid-window.
      gate_sel = 2'd2; per = '{10, 4, 6, 50};
      wait_strobe(t); wait_strobe(t);
      repeat (30) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_buf_a", 64'(buf_a), 64'd0);
      chk("arst_buf_b", 64'(buf_b), 64'd0);
      chk("arst_active", 64'(act_a), 64'd0);
      chk("arst_ovf_b", 64'(ovf_b), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1; r = cyc;
      wait_strobe(t);
      chk("arst_first_strobe", 64'(t - r), 64'd101);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_counter_multi.md
# freq_counter_multi

Multi-channel direct-count frequency meter: the parametrised successor to the single-channel 1 s gate counter. It counts rising edges of CH asynchronous square-wave inputs over a shared gate window of selectable length and latches one result per channel at each window end. Windows run back to back with no dead time. The block sits between the external signal pins and the display/readout logic, for example the LED driver or a register bank.

## Interface
- CH, 4, number of input channels (1..16)
- CNT_W, 32, width of each per-channel result
- CLK_HZ, 100_000_000, sys_clk frequency; must be divisible by 1000
- SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
- sys_clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- sig_in  in  CH  asynchronous test signals, bit i = channel i
- en  in  1  measurement enable
- gate_sel  in  2  gate length: 0 = CLK_HZ cycles (1 s), 1 = CLK_HZ/10, 2 = CLK_HZ/100, 3 = CLK_HZ/1000
- sig_freq_cnt_buf  out  CH*CNT_W  latched edge counts; channel i is at [i*CNT_W +: CNT_W]
- cnt_ovf  out  CH  per-channel saturation flag for the latched window
- cnt_valid  out  1  one-cycle strobe, high when the buffers update
- gate_active  out  1  high while a window is running (state RUN)

## Operation
- Per channel:
  - SYNC_STAGES flop synchroniser, then a registered previous-value flop.
  - edge_i = sync_i & ~prev_i.
  - Edge-detect registers are not cleared by en.
- States:
  - IDLE: counters are cleared. The gate length is loaded from gate_sel into gate_len. If en = 1, go to RUN next cycle; otherwise stay.
  - RUN: gate_cnt increments every cycle from 0. Each edge_i increments acc_i.
    - When gate_cnt == gate_len-1 (last window cycle), the window ends.
    - At window end: gate_cnt goes to 0 and gate_len reloads from gate_sel. Stay in RUN.
    - If en = 0 in any RUN cycle: go to IDLE; the window is aborted.
- Window end, evaluated in the last window cycle and registered on the next edge:
  - buf_i <= acc_i + edge_i, saturated.
  - ovf_i <= saturation occurred at any point in the window.
  - acc_i <= 0. An edge in the first cycle of the next window counts toward the next window.
  - cnt_valid <= 1 for exactly one cycle.
- Arithmetic:
  - acc_i is CNT_W bits and saturates at 2^CNT_W-1; it never wraps.
  - acc_ovf_i is sticky within the window.
  - gate_cnt width is clog2(CLK_HZ).
- gate_sel changes mid-window have no effect until the next window start. The window length is fixed once a window starts.
- Abort (en falls during RUN):
  - buf, cnt_ovf and cnt_valid are not updated; buffers hold their last valid window.
  - acc_i is cleared in IDLE.
  - Re-assertion of en starts a fresh full-length window.
- en low in the last window cycle: abort takes priority and no latch occurs.

## Timing
- Reset values:
  - sig_freq_cnt_buf = 0, cnt_ovf = 0, cnt_valid = 0, gate_active = 0.
  - State = IDLE; acc = 0, gate_cnt = 0, sync/prev = 0.
- Reset mid-window: all outputs return to their reset values immediately (asynchronous). The first window starts 1 cycle after rst_n rises, provided en = 1.
- Input to count latency: a sig_in rise is reflected as edge_i SYNC_STAGES+1 cycles later.
- Window timing:
  - IDLE lasts 1 cycle; gate_active rises the cycle RUN is entered.
  - A window is exactly gate_len cycles.
  - cnt_valid and the new buffer contents appear on the cycle after the last window cycle; both are visible together.
  - Consecutive strobes are exactly gate_len cycles apart.
- Measurement constraints:
  - Measured frequency = buf × (CLK_HZ/gate_len) with ±1 count quantisation.
  - Input high and low times must each be ≥ 2 sys_clk periods to be counted reliably.

## Test plan
All scenarios use CLK_HZ = 10_000 (gates of 10000/1000/100/10 cycles), SYNC_STAGES = 2.
- Basic count:
  - Stimulus: CH = 4, en = 1, gate_sel = 2 (100 cycles); ch0 period 10 cycles, ch1 period 4, ch2 constant 0, ch3 period 50.
  - Required: every steady-state window yields buf = 10, 25, 0, 2; cnt_valid every 100 cycles; cnt_ovf = 0.
- Saturation:
  - Stimulus: CNT_W = 4, gate_sel = 2, ch0 period 4 (25 edges).
  - Required: buf0 = 15 and cnt_ovf[0] = 1. Following a window with period 10 (10 edges): buf0 = 10 and cnt_ovf[0] = 0.
- Gate change:
  - Stimulus: gate_sel switches from 2 to 3 mid-window.
  - Required: the current window still takes 100 cycles; subsequent strobes are 10 cycles apart; ch0 at period 10 gives buf0 = 1.
- Abort:
  - Stimulus: en dropped 40 cycles into a window, then reasserted 5 cycles later.
  - Required: no cnt_valid; buf holds the previous result; gate_active low during the gap; the next strobe comes exactly 100 cycles after gate_active rises.
- Boundary edge:
  - Stimulus: an edge_i timed on the last window cycle, then one on the first cycle of the next window.
  - Required: each edge is counted exactly once, in its own window (no loss, no double count).
- Async reset:
  - Stimulus: rst_n pulsed low mid-window.
  - Required: outputs go to 0 without waiting for a clock; after release, the first strobe comes 1 + gate_len cycles later.
